// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler and its serializer.
package uart_tx_sched_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_MIN_DIV   = 2;

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } arb_state_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } ser_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: latches divisor and byte at frame start, shifts LSB first.
// take_c flags the cycle a pending byte is consumed (from IDLE or at the end of STOP).
module uart_tx_serializer
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic                      core_clk,
  input  logic                      core_rstn,
  input  logic [DIV_W-1:0]          divisor,
  input  logic [UART_DATA_BITS-1:0] tx_byte,
  input  logic                      load,
  output logic                      idle,
  output logic                      take_c,
  output logic                      ser_tx
);

  ser_state_t                state, state_n;
  logic [DIV_W-1:0]          baud_cnt, baud_n;
  logic [DIV_W-1:0]          div_q, div_n;
  logic [2:0]                bit_cnt, bit_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic                      tx_n;
  logic [DIV_W-1:0]          div_eff;

  assign div_eff = (divisor < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : divisor;
  assign idle    = (state == IDLE);

  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      div_q    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      ser_tx   <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      div_q    <= div_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      ser_tx   <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    div_n   = div_q;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    tx_n    = ser_tx;
    take_c  = 1'b0;
    case (state)
      IDLE: ;
      START: begin
        if (baud_cnt == '0) begin
          state_n = DATA;
          tx_n    = shreg[0];
          baud_n  = div_q - DIV_W'(1);
          bit_n   = '0;
        end else begin
          baud_n = baud_cnt - DIV_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == '0) begin
          baud_n = div_q - DIV_W'(1);
          if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
          end
        end else begin
          baud_n = baud_cnt - DIV_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt == '0) state_n = IDLE;
        else                baud_n  = baud_cnt - DIV_W'(1);
      end
      default: state_n = IDLE;
    endcase
    // A pending byte starts a new frame directly, so back-to-back frames have no idle bit.
    if (load && (state == IDLE || (state == STOP && baud_cnt == '0))) begin
      take_c  = 1'b1;
      state_n = START;
      tx_n    = 1'b0;
      div_n   = div_eff;
      baud_n  = div_eff - DIV_W'(1);
      shreg_n = tx_byte;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin, packet-locked sharing of one UART transmitter between NREQ byte streams.
// Optional stall timeout on the lock owner: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned DIV_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                           core_clk,
  input  logic                           core_rstn,
  input  logic                           cfg_enable,
  input  logic [DIV_W-1:0]               cfg_divisor,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ*UART_DATA_BITS-1:0] req_data,
  input  logic [NREQ-1:0]                req_last,
  output logic [NREQ-1:0]                req_ready,
  output logic [NREQ-1:0]                grant,
  output logic                           busy,
  output logic                           timeout_err,
  output logic                           ser_tx
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("uart_tx_sched: unsupported parameter values");
  end

  arb_state_t                arb_state, arb_n;
  logic [NREQ-1:0]           grant_n;
  logic [PTR_W-1:0]          ptr, ptr_n;
  logic                      timeout_n;
  logic                      hold_valid;
  logic [UART_DATA_BITS-1:0] hold_data;
  logic [UART_DATA_BITS-1:0] acc_data;
  logic [NREQ-1:0]           fire;
  logic                      accept, accept_last;
  logic                      ser_idle, ser_take;
  logic                      stall_expire;
  logic                      found;
  int unsigned               cand;

  assign req_ready   = grant & {NREQ{~hold_valid}};
  assign fire        = req_valid & req_ready;
  assign accept      = |fire;
  assign accept_last = |(fire & req_last);
  assign busy        = (arb_state == LOCKED) | hold_valid | ~ser_idle;

  always_comb begin
    acc_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) acc_data = acc_data | req_data[i*UART_DATA_BITS +: UART_DATA_BITS];
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;
  logic               owner_valid;

  assign owner_valid  = |(req_valid & grant);
  assign stall_expire = (arb_state == LOCKED) && !owner_valid &&
                        (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge core_clk) begin
    if (!core_rstn || arb_state != LOCKED || owner_valid || stall_expire) stall_cnt <= '0;
    else                                                                  stall_cnt <= stall_cnt + STALL_W'(1);
  end
`else
  assign stall_expire = 1'b0;
`endif

  always_ff @(posedge core_clk) begin
    if (!core_rstn) begin
      arb_state   <= UNLOCKED;
      grant       <= '0;
      ptr         <= PTR_W'(NREQ - 1);
      timeout_err <= 1'b0;
      hold_valid  <= 1'b0;
      hold_data   <= '0;
    end else begin
      arb_state   <= arb_n;
      grant       <= grant_n;
      ptr         <= ptr_n;
      timeout_err <= timeout_n;
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= acc_data;
      end else if (ser_take) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Lock release and re-arbitration never share an edge: UNLOCKED always lasts a cycle.
  always_comb begin
    arb_n     = arb_state;
    grant_n   = grant;
    ptr_n     = ptr;
    timeout_n = 1'b0;
    found     = 1'b0;
    cand      = 0;
    case (arb_state)
      UNLOCKED: begin
        if (cfg_enable && |req_valid) begin
          for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(ptr) + k) % NREQ;
            if (!found && req_valid[PTR_W'(cand)]) begin
              found   = 1'b1;
              arb_n   = LOCKED;
              grant_n = NREQ'(1) << cand;
              ptr_n   = PTR_W'(cand);
            end
          end
        end
      end
      LOCKED: begin
        if (accept_last) begin
          arb_n   = UNLOCKED;
          grant_n = '0;
        end else if (stall_expire) begin
          arb_n     = UNLOCKED;
          grant_n   = '0;
          timeout_n = 1'b1;
        end
      end
      default: begin
        arb_n   = UNLOCKED;
        grant_n = '0;
      end
    endcase
  end

  uart_tx_serializer #(
    .DIV_W(DIV_W)
  ) u_ser (
    .core_clk (core_clk),
    .core_rstn(core_rstn),
    .divisor  (cfg_divisor),
    .tx_byte  (hold_data),
    .load     (hold_valid),
    .idle     (ser_idle),
    .take_c   (ser_take),
    .ser_tx   (ser_tx)
  );

endmodule
